// File: rtl/crc8_calculator.sv
// Byte-wide CRC-8 accumulator: one full non-reflected byte update per enabled clock,
// with a synchronous restart and an asynchronous active-low reset.
module crc8_calculator #(
  parameter logic [7:0] POLY      = 8'h07,
  parameter logic [7:0] INIT      = 8'h00,
  parameter logic [7:0] FINAL_XOR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crc_enable,
  input  logic [7:0] data_in,
  input  logic       crc_reset,
  output logic [7:0] crc_out,
  output logic [7:0] crc_final
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Eight MSB-first shift/XOR steps unrolled into a single combinational stage.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (crc_reset) begin
      crc_d = INIT;
    end else if (crc_enable) begin
      crc_d = crc8_byte(crc_q, data_in);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out   = crc_q;
  assign crc_final = crc_q ^ FINAL_XOR;

endmodule

// File: tb/tb_crc8_calculator.sv
// Directed bench for crc8_calculator: a table of single-cycle vectors plus hand-written
// sequences for the check string, idle gaps and an asynchronous mid-stream reset.
module tb_crc8_calculator;

  logic       clk;
  logic       rst;
  logic       crc_enable;
  logic [7:0] data_in;
  logic       crc_reset;
  logic [7:0] crc_out;
  logic [7:0] crc_final;
  logic [7:0] crc_out_x;
  logic [7:0] crc_final_x;

  int checks;
  int errors;

  crc8_calculator dut (
    .clk        (clk),
    .rst        (rst),
    .crc_enable (crc_enable),
    .data_in    (data_in),
    .crc_reset  (crc_reset),
    .crc_out    (crc_out),
    .crc_final  (crc_final)
  );

  // Second instance with a non-zero output mask so crc_final is distinguishable from crc_out.
  crc8_calculator #(.FINAL_XOR(8'h55)) dut_x (
    .clk        (clk),
    .rst        (rst),
    .crc_enable (crc_enable),
    .data_in    (data_in),
    .crc_reset  (crc_reset),
    .crc_out    (crc_out_x),
    .crc_final  (crc_final_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rs;
    logic [7:0] data;
    logic [7:0] exp_crc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end else begin
      $display("ok   %s value=%02h", name, act);
    end
  endtask

  // Called at a negedge: drive inputs, take one rising edge, return at the next negedge.
  task automatic step(input logic en, input logic rs, input logic [7:0] d);
    crc_enable = en;
    crc_reset  = rs;
    data_in    = d;
    @(posedge clk);
    @(negedge clk);
    crc_enable = 1'b0;
    crc_reset  = 1'b0;
  endtask

  initial begin
    logic [7:0] msg [9];
    checks = 0;
    errors = 0;
    rst = 1'b0;
    crc_enable = 1'b0;
    crc_reset = 1'b0;
    data_in = 8'h00;

    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h01, 8'h07};
    vecs[2]  = '{1'b1, 1'b0, 8'h02, 8'h1B};
    vecs[3]  = '{1'b1, 1'b1, 8'hAA, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 8'hFF, 8'hF3};
    vecs[5]  = '{1'b0, 1'b0, 8'h55, 8'hF3};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h01, 8'h07};
    vecs[9]  = '{1'b0, 1'b0, 8'hA5, 8'h07};
    vecs[10] = '{1'b1, 1'b1, 8'h07, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 8'h07, 8'h15};

    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

    #12;
    check("reset_crc_out", crc_out, 8'h00);
    check("reset_crc_final", crc_final, 8'h00);
    check("reset_final_masked", crc_final_x, 8'h55);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].rs, vecs[i].data);
      check($sformatf("vec%0d_crc_out", i), crc_out, vecs[i].exp_crc);
      check($sformatf("vec%0d_crc_final", i), crc_final, vecs[i].exp_crc);
    end
    step(1'b1, 1'b0, 8'h15);
    check("self_cancel", crc_out, 8'h00);

    // Standard check string back-to-back.
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, msg[i]);
    check("check_string_final", crc_final, 8'hF4);
    check("check_string_masked", crc_final_x, 8'hA1);

    // Long idle must hold the result.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'(i * 37));
    check("hold_after_idle", crc_out, 8'hF4);

    // Same string with 0..5 idle cycles between bytes.
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, msg[i]);
      for (int g = 0; g < (i % 6); g++) step(1'b0, 1'b0, 8'hC3);
    end
    check("gapped_string_final", crc_final, 8'hF4);

    // Asynchronous reset between edges after three bytes.
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h31);
    step(1'b1, 1'b0, 8'h32);
    step(1'b1, 1'b0, 8'h33);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_crc_out", crc_out, 8'h00);
    check("async_reset_crc_final", crc_final_x, 8'h55);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h01);
    check("first_byte_after_reset", crc_out, 8'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc8_calculator.md
CRC8_CALCULATOR -- requirements
Module: crc8_calculator

Interface
REQ-001 SHALL have parameter POLY, default 8'h07, the CRC-8 generator polynomial with the implicit x^8 term omitted.
REQ-002 SHALL have parameter INIT, default 8'h00, the CRC register value after reset and after crc_reset.
REQ-003 SHALL have parameter FINAL_XOR, default 8'h00, the mask XORed into crc_final.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: crc_enable  input  1  folds data_in into the CRC on this clock edge.
REQ-008 SHALL have port: data_in  input  8  byte to accumulate.
REQ-009 SHALL have port: crc_reset  input  1  synchronous restart of the CRC to INIT.
REQ-010 SHALL have port: crc_out  output  8  registered running CRC value.
REQ-011 SHALL have port: crc_final  output  8  finished CRC, equal to crc_out XOR FINAL_XOR (combinational from the register).

Function
REQ-012 SHALL keep one 8-bit CRC state register, and crc_out SHALL drive it directly.
REQ-013 SHALL update the register on a clk edge with crc_enable=1 and crc_reset=0, using the byte-wise update below.
REQ-014 Byte-wise update SHALL be: c = crc XOR data_in, then 8 iterations MSB-first of: if c[7] then c = (c<<1) XOR POLY else c = c<<1, each truncated to 8 bits.
REQ-015 The CRC SHALL be non-reflected for both input and output.
REQ-016 The full byte update SHALL complete in one cycle, so crc_out reflects a byte on the cycle after its enable edge.
REQ-017 SHALL accept back-to-back bytes on consecutive cycles with no stall and no ready/valid handshake.
REQ-018 On a clk edge with crc_reset=1, the register SHALL load INIT.
REQ-019 crc_reset SHALL take priority over crc_enable when both are 1 (the byte is discarded).
REQ-020 With crc_enable=0 and crc_reset=0, the register SHALL hold its value indefinitely.
REQ-021 crc_final SHALL follow the register with zero cycles of latency; it is not a separately registered copy.
REQ-022 data_in SHALL be ignored whenever crc_enable=0; X on data_in while disabled SHALL NOT affect state.
REQ-023 All arithmetic SHALL be 8-bit modulo-2 (XOR/shift) only: no carries, no byte counter, no length limit.
REQ-024 The register SHALL have no overflow or wrap condition; any number of bytes is accumulated.

Reset
REQ-025 On rst=0, the register SHALL load INIT asynchronously, independent of clk.
REQ-026 During reset, crc_out SHALL be INIT (8'h00) and crc_final SHALL be INIT XOR FINAL_XOR (8'h00).
REQ-027 Reset mid-accumulation SHALL discard all prior bytes.
REQ-028 Reset deassertion SHALL be synchronized externally; the first enabled edge after release SHALL process normally from INIT.
REQ-029 No other state SHALL exist beyond the CRC register.

Verification
REQ-030 Scenario: reset, then enable one byte 8'h01 -> crc_out=8'h07 and crc_final=8'h07 on the next cycle.
REQ-031 Scenario: reset, then bytes 8'h01, 8'h02 back-to-back -> crc_out=8'h1B.
REQ-032 Scenario: reset, then single byte 8'hFF -> 8'hF3; single byte 8'h00 -> 8'h00.
REQ-033 Scenario: ASCII "123456789" (8'h31..8'h39), one per cycle -> crc_final=8'hF4.
REQ-034 Scenario: crc_enable=1 and crc_reset=1 in the same cycle with data 8'hAA -> register=8'h00; then enable gaps of 0-5 idle cycles between bytes -> same result as back-to-back.
REQ-035 Scenario: assert rst=0 asynchronously between clock edges after 3 bytes -> crc_out=8'h00 immediately, before the next clk edge.
